if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline: PC register, PC+4 adder, redirect mux and IF/ID pipeline register.
- Drives the instruction memory address and presents the fetched instruction and PC+4 to the decode stage.
- Branches resolve in ID; jumps decode in ID.
- Also keeps fetch/redirect performance counters and a sticky misalignment flag for the textual trace bench.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INS, 32'h0000_0000, instruction word injected into IF/ID on flush (sll $0,$0,0).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  load-use hazard; hold PC and IF/ID.
- branch_taken  in  1  ID resolved a taken beq/bne.
- branch_target  in  32  byte address of branch destination.
- jump  in  1  ID decoded j/jal.
- jump_index  in  26  instr[25:0] of the jump in ID.
- imem_rdata  in  32  instruction word at imem_addr (combinational read).
- imem_addr  out  32  equals pc_out.
- pc_out  out  32  current PC.
- if_id_ins  out  32  registered instruction to ID.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  0 when IF/ID holds an injected NOP.
- fetch_count  out  32  instructions accepted into IF/ID.
- redirect_count  out  32  branch/jump redirects taken.
- misalign_err  out  1  sticky; a redirect target had nonzero bits [1:0].

Behaviour:
- Reset (reset_n low, asynchronous):
  - pc_out = RESET_PC; if_id_ins = NOP_INS; if_id_pc_plus4 = 0; if_id_valid = 0.
  - Both counters = 0; misalign_err = 0.
  - All of the above hold while reset_n is low.
- pc_plus4 = pc_out + 4, 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- jump_target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
- Per-cycle priority on a rising edge: stall > branch_taken > jump > sequential.
  - stall=1: PC, IF/ID and counters hold. branch_taken and jump are ignored; ID re-asserts them after the stall clears.
  - branch_taken=1, stall=0: PC <= {branch_target[31:2], 2'b00}; IF/ID <= NOP_INS, pc_plus4 0, valid 0 (flush of the wrong-path fetch); redirect_count +1. If branch_target[1:0] != 0, misalign_err <= 1.
  - jump=1, branch_taken=0, stall=0: PC <= jump_target; IF/ID flushed as above; redirect_count +1.
  - Both branch_taken and jump=1: treated as branch; jump dropped.
  - Otherwise: PC <= pc_plus4; IF/ID <= {imem_rdata, pc_plus4, valid 1}; fetch_count +1.
- Latency:
  - Instruction at PC appears on if_id_ins one edge after PC is presented.
  - A redirect costs one bubble: the target instruction reaches IF/ID two edges after the redirect request edge.
- Counters wrap at 2^32 silently.
- misalign_err clears only on reset.
- No combinational path from stall, branch_taken or jump to imem_addr; imem_addr is purely registered.
- Reset asserted mid-stall or mid-redirect: state returns to reset values immediately. First fetch after release is from RESET_PC.

Test Plan:
- Reset release, stall=0, imem returns addr+32'h1000: edges 1..3 give if_id_ins 32'h1000/1004/1008, pc_out 4/8/C, fetch_count 3, if_id_valid 1.
- stall=1 for 2 cycles at pc=8: pc_out stays 8, if_id_ins and fetch_count frozen. Stall also asserted with branch_taken: no redirect, redirect_count unchanged.
- branch_taken with branch_target 32'h40 at pc=C:
  - Next edge: pc_out 32'h40, if_id_ins NOP_INS, valid 0, redirect_count 1.
  - Following edge: if_id_ins 32'h1040.
- jump with jump_index 26'h10 while if_id_pc_plus4 = 32'h1000_0008 -> pc_out 32'h1000_0040, IF/ID flushed. branch_taken and jump together -> branch_target wins.
- branch_target 32'h42 -> pc_out 32'h40, misalign_err 1 and stays 1 through later cycles until reset.
- reset_n pulled low asynchronously between edges during a redirect -> all outputs at reset values before the next edge. PC at 32'hFFFF_FFFC sequential -> wraps to 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, redirect mux and IF/ID register,
// plus fetch/redirect counters and a sticky misaligned-target flag.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_aligned;

  assign pc_plus4       = pc_out + XLEN'(4);
  assign jump_target    = {if_id_pc_plus4[31:28], jump_index, 2'b00};
  assign branch_aligned = {branch_target[31:2], 2'b00};

  // Memory address comes straight from the PC register; no control input reaches it.
  assign imem_addr = pc_out;

  // Priority: stall > branch > jump > sequential fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_out         <= RESET_PC;
      if_id_ins      <= NOP_INS;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
      redirect_count <= '0;
      misalign_err   <= 1'b0;
    end else if (!stall) begin
      if (branch_taken || jump) begin
        pc_out         <= branch_taken ? branch_aligned : jump_target;
        if_id_ins      <= NOP_INS;
        if_id_pc_plus4 <= '0;
        if_id_valid    <= 1'b0;
        redirect_count <= redirect_count + XLEN'(1);
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          misalign_err <= 1'b1;
        end
      end else begin
        pc_out         <= pc_plus4;
        if_id_ins      <= imem_rdata;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
        fetch_count    <= fetch_count + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations,
// then randomized control traffic checked every cycle against a behavioural model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INS  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, pc_out, if_id_ins, if_id_pc_plus4, fetch_count, redirect_count;
  logic        if_id_valid, misalign_err;

  int tests = 0;
  int failed = 0;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INS(NOP_INS)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc_out(pc_out), .if_id_ins(if_id_ins),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .redirect_count(redirect_count),
    .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  // Instruction memory image: each word is its byte address plus 0x1000.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h1000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural view of what the fetch stage must hold.
  logic [31:0] m_pc, m_ins, m_pcp4, m_fc, m_rc;
  logic        m_valid, m_mis;

  always @(posedge clock or negedge reset_n) begin
    logic [31:0] tgt;
    if (!reset_n) begin
      m_pc = RESET_PC; m_ins = NOP_INS; m_pcp4 = 0; m_valid = 0;
      m_fc = 0; m_rc = 0; m_mis = 0;
    end else if (stall) begin
      // everything holds
    end else if (branch_taken || jump) begin
      if (branch_taken) begin
        tgt = branch_target & ~32'h3;
        if (branch_target % 4 != 0) m_mis = 1;
      end else begin
        tgt = (m_pcp4 & 32'hF000_0000) | ({6'b0, jump_index} * 4);
      end
      m_pc = tgt; m_ins = NOP_INS; m_pcp4 = 0; m_valid = 0;
      m_rc = m_rc + 1;
    end else begin
      m_ins = mem(m_pc);
      m_pc = m_pc + 4;
      m_pcp4 = m_pc;
      m_valid = 1;
      m_fc = m_fc + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_ins", if_id_ins, m_ins);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pcp4);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("fetch_count", fetch_count, m_fc);
    chk("redirect_count", redirect_count, m_rc);
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
  end

  // Apply controls at a negedge, let one rising edge pass, return at next negedge + 2.
  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    @(negedge clock);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_ins", if_id_ins, NOP_INS);
    chk("rst_valid", 32'(if_id_valid), 32'd0);

    // Sequential fetch after release.
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("seq1_ins", if_id_ins, 32'h1000);
    chk("seq1_pc", pc_out, 32'h4);
    step(0, 0, 0, 0, 0);
    chk("seq2_ins", if_id_ins, 32'h1004);
    chk("seq2_pc", pc_out, 32'h8);

    // Stall at pc=8, then stall with a branch that must be ignored.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("stall_pc", pc_out, 32'h8);
    chk("stall_fc", fetch_count, 32'd2);
    step(1, 1, 32'h80, 0, 0);
    chk("stall_br_pc", pc_out, 32'h8);
    chk("stall_br_rc", redirect_count, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("seq3_ins", if_id_ins, 32'h1008);
    chk("seq3_pc", pc_out, 32'hC);
    chk("seq3_fc", fetch_count, 32'd3);
    chk("seq3_valid", 32'(if_id_valid), 32'd1);

    // Branch to 0x40 at pc=C: one bubble, then target instruction.
    step(0, 1, 32'h40, 0, 0);
    chk("br_pc", pc_out, 32'h40);
    chk("br_ins", if_id_ins, NOP_INS);
    chk("br_valid", 32'(if_id_valid), 32'd0);
    chk("br_rc", redirect_count, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("br_tgt_ins", if_id_ins, 32'h1040);

    // PC wrap from 0xFFFF_FFFC.
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_pcp4", if_id_pc_plus4, 32'h0);

    // Jump using the upper nibble of if_id_pc_plus4 = 0x1000_0008.
    step(0, 1, 32'h1000_0004, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("jmp_pre_pcp4", if_id_pc_plus4, 32'h1000_0008);
    step(0, 0, 0, 1, 26'h10);
    chk("jmp_pc", pc_out, 32'h1000_0040);
    chk("jmp_valid", 32'(if_id_valid), 32'd0);

    // Branch and jump together: branch wins.
    step(0, 1, 32'h200, 1, 26'h3FF);
    chk("both_pc", pc_out, 32'h200);

    // Misaligned branch target: aligned PC, sticky flag.
    step(0, 1, 32'h42, 0, 0);
    chk("mis_pc", pc_out, 32'h40);
    chk("mis_flag", 32'(misalign_err), 32'd1);
    repeat (4) step(0, 0, 0, 0, 0);
    chk("mis_sticky", 32'(misalign_err), 32'd1);

    // Asynchronous reset between edges during a redirect.
    stall = 0; branch_taken = 1; branch_target = 32'h300; jump = 0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pc", pc_out, RESET_PC);
    chk("arst_ins", if_id_ins, NOP_INS);
    chk("arst_rc", redirect_count, 32'd0);
    chk("arst_fc", fetch_count, 32'd0);
    chk("arst_mis", 32'(misalign_err), 32'd0);
    branch_taken = 0;
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("post_rst_ins", if_id_ins, mem(RESET_PC));
    chk("post_rst_pcp4", if_id_pc_plus4, RESET_PC + 32'd4);

    // Randomized control traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] bt;
      r = $urandom_range(0, 99);
      bt = $urandom;
      if ($urandom_range(0, 9) != 0) bt[1:0] = 2'b00;
      reset_n = ($urandom_range(0, 199) != 0);
      stall = (r < 20);
      branch_taken = ($urandom_range(0, 99) < 15);
      branch_target = bt;
      jump = ($urandom_range(0, 99) < 12);
      jump_index = 26'($urandom);
      @(negedge clock);
    end
    reset_n = 1'b1; stall = 0; branch_taken = 0; jump = 0;
    @(negedge clock);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
